// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter that serialises requesters' toggle masks onto a
// shared flip-flop bank held locally and exposed as q.
module tff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic                  clear,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  drop,
  output logic                  t_en,
  output logic [WIDTH-1:0]      t_out,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    last_win;
  logic [WIDTH-1:0] hold;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] win_mask;
  logic [NREQ-1:0]  win_oh;

  // Search begins one past the previous winner and wraps around.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_win) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    win_mask = mask[int'(win_idx)*WIDTH +: WIDTH];
    win_oh   = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_win <= IW'(NREQ - 1);
      hold     <= '0;
      gnt      <= '0;
      ack      <= '0;
      drop     <= 1'b0;
      t_en     <= 1'b0;
      t_out    <= '0;
      busy     <= 1'b0;
      q        <= '0;
    end else begin
      ack  <= '0;
      drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            gnt      <= win_oh;
            hold     <= win_mask;
            last_win <= win_idx;
            busy     <= 1'b1;
            t_en     <= 1'b1;
            t_out    <= win_mask;
          end
        end
        GRANT: begin
          state <= DONE;
          t_en  <= 1'b0;
          t_out <= '0;
          ack   <= gnt;
          drop  <= clear;
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // A clear always wins over the pending toggle.
      if (clear)
        q <= '0;
      else if (state == GRANT)
        q <= q ^ hold;
    end
  end

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed bench for tff_bank_arbiter: reset, single toggles,
// fairness, clear override and zero-mask transactions.
module tb_tff_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] mask;
  logic        clear;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        drop;
  logic        t_en;
  logic [7:0]  t_out;
  logic [7:0]  q;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq;

  tff_bank_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .mask(mask),
    .clear(clear), .gnt(gnt), .ack(ack), .drop(drop),
    .t_en(t_en), .t_out(t_out), .q(q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int r, input logic [7:0] m, input bit clr);
    logic [3:0] oh;
    oh = 4'(1 << r);
    req = oh;
    mask[r*8 +: 8] = m;
    tick();
    req = '0;
    chk("gnt", gnt, oh);
    chk("t_en", t_en, 1);
    chk("t_out", t_out, m);
    chk("busy", busy, 1);
    chk("ack_grant", ack, 0);
    clear = clr;
    tick();
    clear = 1'b0;
    expq = clr ? 8'h00 : expq ^ m;
    chk("q_apply", q, expq);
    chk("ack", ack, oh);
    chk("drop", drop, clr);
    chk("t_en_done", t_en, 0);
    chk("t_out_done", t_out, 0);
    tick();
    chk("ack_end", ack, 0);
    chk("gnt_end", gnt, 0);
    chk("busy_end", busy, 0);
    chk("drop_end", drop, 0);
    chk("q_end", q, expq);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    mask  = '0;
    clear = 1'b0;
    expq  = '0;
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", q, 0);
    chk("rst_t_en", t_en, 0);
    reset = 1'b0;
    tick();

    txn(1, 8'h5A, 1'b0);

    // Reset in the middle of a grant.
    req = 4'b0100;
    mask[16 +: 8] = 8'h11;
    tick();
    req = '0;
    chk("mid_gnt", gnt, 4'b0100);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ten", t_en, 0);
    chk("mid_rst_tout", t_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_ack", ack, 0);
    expq = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ack", ack, 0);

    // Fairness with all requesters held high.
    mask = 32'h08040201;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh;
      logic [7:0] m;
      oh = 4'(1 << (i % 4));
      m  = 8'(1 << (i % 4));
      tick();
      chk("fair_gnt", gnt, oh);
      chk("fair_tout", t_out, m);
      expq = expq ^ m;
      tick();
      chk("fair_ack", ack, oh);
      chk("fair_q", q, expq);
      tick();
      chk("fair_idle", busy, 0);
    end
    req = '0;
    chk("fair_qfinal", q, 8'h0E);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    expq = '0;
    chk("clear_q", q, 0);

    txn(2, 8'hA5, 1'b0);
    chk("pair_q1", q, 8'hA5);
    txn(2, 8'hA5, 1'b0);
    chk("pair_q2", q, 8'h00);

    txn(0, 8'h3C, 1'b0);
    chk("pre_clr_q", q, 8'h3C);
    txn(1, 8'hFF, 1'b1);
    chk("clr_q", q, 8'h00);

    txn(0, 8'h81, 1'b0);
    txn(3, 8'h00, 1'b0);
    chk("zero_q", q, 8'h81);

    tick();
    chk("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_bank_arbiter.md
# tff_bank_arbiter

Round-robin arbiter and sequencer for a shared bank of WIDTH toggle flip-flops. Up to NREQ requesters each present a toggle mask. The block grants one requester at a time, applies that mask to the bank (q ← q XOR mask) in a single cycle, and acknowledges completion. The block holds the bank state itself and exposes it as `q`. It sits between client logic and any consumer of the toggled state, so each requester sees its update applied atomically.

## Interface
- `WIDTH`, 8: number of toggle bits in the bank.
- `NREQ`, 4: number of requesters (≥2).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `mask`  in  NREQ*WIDTH  toggle mask; requester i uses bits [i*WIDTH +: WIDTH].
- `clear`  in  1  synchronous clear of the bank to zero.
- `gnt`  out  NREQ  one-hot grant; registered.
- `ack`  out  NREQ  one-hot, one-cycle completion pulse.
- `drop`  out  1  pulses with `ack` when the granted toggle was overridden by `clear`.
- `t_en`  out  1  high during the apply cycle.
- `t_out`  out  WIDTH  mask being applied; zero when `t_en` is low.
- `q`  out  WIDTH  bank state.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE → GRANT → DONE → IDLE. Encoding is free; the state register is registered.
- **IDLE:**
  - If any `req` bit is high, pick the winner round-robin. Search starts at (last_winner+1) mod NREQ.
  - Register `gnt`, capture the winner's mask into a hold register, update last_winner, and go to GRANT.
  - If no `req` bit is high, stay in IDLE.
- **GRANT:**
  - `t_en`=1 and `t_out`=held mask.
  - At the closing edge, q ← q XOR held mask, then go to DONE.
- **DONE:**
  - `ack[winner]`=1 and `gnt` stays asserted.
  - At the closing edge, clear `gnt` and go to IDLE.
- `clear` has priority over the toggle in every state: q ← 0.
  - If `clear` is high during GRANT, the toggle is lost but the transaction still completes. DONE then asserts `ack` with `drop`=1.
- `mask` and `req` are sampled only in IDLE. Changes after the grant are ignored.
  - A requester dropping `req` mid-transaction does not abort it.
- A requester must drop `req` in the cycle after `ack`. A `req` still high in IDLE counts as a new request, subject to the round-robin pointer.
- A zero mask runs a full transaction; q is unchanged and `ack` is issued.
- Reset values: state=IDLE, `gnt`=0, `ack`=0, `drop`=0, `t_en`=0, `t_out`=0, `q`=0, `busy`=0, last_winner=NREQ-1 (so requester 0 has first priority).

## Timing
- Request seen at edge E0 (in IDLE):
  - `gnt` and `busy` high after E0.
  - `t_en` high during E0–E1; q updated at E1.
  - `ack` high during E1–E2; IDLE after E2.
- Throughput: one transaction per 3 cycles at most. Latency from `req` to `ack` is 2 cycles.
- Reset asserted in any state clears every output immediately, without waiting for a clock edge. A transaction in progress is discarded and no `ack` is issued.
- `clear` and reset are independent: `clear` is synchronous and affects only `q`, `drop`.

## Test plan
- **Reset mid-transaction:** assert `reset` during GRANT (WIDTH=8) → all outputs 0 immediately. After release, with `req`=4'b1111, the first `gnt` is 4'b0001.
- **Single toggle pair:** q=0x00, `req[2]`=1, mask2=0xA5 → `gnt`=4'b0100, `t_en`=1 with `t_out`=0xA5, q=0xA5, one-cycle `ack`=4'b0100. Repeating the request gives q=0x00.
- **Fairness:** `req`=4'b1111 held continuously → `gnt` order is 0,1,2,3,0 with one grant every 3 cycles, and `ack` pulses in the same order.
- **Clear during apply:** q=0x3C, `req[1]` with mask1=0xFF, `clear`=1 in the GRANT cycle → q=0x00, `ack`=4'b0010 with `drop`=1.
- **Zero mask and short request:** `req[3]` pulsed one cycle in IDLE with mask3=0x00 → full 3-cycle transaction, q unchanged, `ack[3]` pulses once, `busy` returns to 0.
